regs_wb_arb: RTL and testbench

- Write-back controller in front of the 32-entry register file (single write port; synchronous dual read).
- Shares the one write port between two requesters, ALU and LSU, using round-robin valid/ready arbitration.
- Keeps a per-register pending scoreboard so issue logic can stall on RAW hazards.
- Supplies registered forwarding for a write that lands on the same edge as a regfile read, since that read returns the stale value.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/rr_arb2.sv | 42 ++++
 rtl/regs_wb_arb.sv | 141 ++++++++++++++
 tb/tb_regs_wb_arb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared register-file constants and requester-id encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   localparam int REG_W = 5;
   localparam int NREGS = 32;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   // Requester ids, also the encoding of the round-robin priority flop
   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_LSU = 1'b1;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter. Combinational grant with a
//               priority flop that favours the requester not served last.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
   import riscv_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1,
   output logic prio
);

   logic r_prio;

   // Grant: a lone requester always wins; on contention prio picks the winner
   always_comb begin
      gnt0 = req0 & (~req1 | (r_prio == REQ_ALU));
      gnt1 = req1 & ~gnt0;
   end

   // Priority flips to the other requester after each grant, holds otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio <= REQ_ALU;
      end else if (gnt0) begin
         r_prio <= REQ_LSU;
      end else if (gnt1) begin
         r_prio <= REQ_ALU;
      end
   end

   assign prio = r_prio;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/regs_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : regs_wb_arb
// Description : Write-back controller for the 32-entry register file. Shares
//               the single write port between ALU and LSU, tracks pending
//               destinations for RAW stalls and forwards a write that lands
//               on the same edge as a regfile read.
// Revision    : 1.0 - initial release
// ============================================================================
module regs_wb_arb
   import riscv_pkg::*;
#(
   parameter int W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alu_valid,
   output logic             alu_ready,
   input  logic [REG_W-1:0] alu_rd,
   input  logic [W-1:0]     alu_val,
   input  logic             lsu_valid,
   output logic             lsu_ready,
   input  logic [REG_W-1:0] lsu_rd,
   input  logic [W-1:0]     lsu_val,
   input  logic             issue_valid,
   input  logic [REG_W-1:0] issue_rd,
   input  logic             ren,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   output logic             stall,
   output logic             wen,
   output logic [REG_W-1:0] rd,
   output logic [W-1:0]     rd_val,
   output logic             fwd1_hit,
   output logic [W-1:0]     fwd1_val,
   output logic             fwd2_hit,
   output logic [W-1:0]     fwd2_val
);

   logic             w_gnt_alu;
   logic             w_gnt_lsu;
   logic             w_prio;
   logic             w_gnt_any;
   logic [REG_W-1:0] w_gnt_rd;
   logic [W-1:0]     w_gnt_val;
   logic [NREGS-1:0] w_pend_nxt;

   logic             r_wen;
   logic [REG_W-1:0] r_rd;
   logic [W-1:0]     r_rd_val;
   logic [NREGS-1:0] r_pending;
   logic             r_fwd1_hit;
   logic [W-1:0]     r_fwd1_val;
   logic             r_fwd2_hit;
   logic [W-1:0]     r_fwd2_val;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req0  (alu_valid),
      .req1  (lsu_valid),
      .gnt0  (w_gnt_alu),
      .gnt1  (w_gnt_lsu),
      .prio  (w_prio)
   );

   // Select the granted request's destination and data
   always_comb begin
      w_gnt_any = w_gnt_alu | w_gnt_lsu;
      w_gnt_rd  = w_gnt_alu ? alu_rd  : lsu_rd;
      w_gnt_val = w_gnt_alu ? alu_val : lsu_val;
   end

   // Write port: one cycle after grant; x0 writes are swallowed here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wen    <= 1'b0;
         r_rd     <= REG_ZERO;
         r_rd_val <= '0;
      end else if (w_gnt_any) begin
         r_wen    <= (w_gnt_rd != REG_ZERO);
         r_rd     <= w_gnt_rd;
         r_rd_val <= w_gnt_val;
      end else begin
         r_wen    <= 1'b0;
      end
   end

   // Scoreboard next state: clear the retiring write first so an issue to
   // the same register on the same edge leaves it pending
   always_comb begin
      w_pend_nxt = r_pending;
      if (r_wen) begin
         w_pend_nxt[r_rd] = 1'b0;
      end
      if (issue_valid && (issue_rd != REG_ZERO)) begin
         w_pend_nxt[issue_rd] = 1'b1;
      end
      w_pend_nxt[0] = 1'b0;
   end

   // Scoreboard register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_pend_nxt;
      end
   end

   // Forwarding: the regfile read on this edge misses the write landing now
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fwd1_hit <= 1'b0;
         r_fwd1_val <= '0;
         r_fwd2_hit <= 1'b0;
         r_fwd2_val <= '0;
      end else if (ren) begin
         r_fwd1_hit <= r_wen && (r_rd == rs1) && (r_rd != REG_ZERO);
         r_fwd1_val <= r_rd_val;
         r_fwd2_hit <= r_wen && (r_rd == rs2) && (r_rd != REG_ZERO);
         r_fwd2_val <= r_rd_val;
      end else begin
         r_fwd1_hit <= 1'b0;
         r_fwd2_hit <= 1'b0;
      end
   end

   assign alu_ready = w_gnt_alu;
   assign lsu_ready = w_gnt_lsu;
   assign stall     = ren && (r_pending[rs1] || r_pending[rs2]);
   assign wen       = r_wen;
   assign rd        = r_rd;
   assign rd_val    = r_rd_val;
   assign fwd1_hit  = r_fwd1_hit;
   assign fwd1_val  = r_fwd1_val;
   assign fwd2_hit  = r_fwd2_hit;
   assign fwd2_val  = r_fwd2_val;

endmodule : regs_wb_arb
`default_nettype wire

// File: tb/tb_regs_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regs_wb_arb
// Description : Directed self-checking bench for regs_wb_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regs_wb_arb;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         alu_valid, alu_ready;
   logic [4:0]   alu_rd;
   logic [W-1:0] alu_val;
   logic         lsu_valid, lsu_ready;
   logic [4:0]   lsu_rd;
   logic [W-1:0] lsu_val;
   logic         issue_valid;
   logic [4:0]   issue_rd;
   logic         ren;
   logic [4:0]   rs1, rs2;
   logic         stall, wen;
   logic [4:0]   rd;
   logic [W-1:0] rd_val;
   logic         fwd1_hit, fwd2_hit;
   logic [W-1:0] fwd1_val, fwd2_val;

   int n_checks = 0;
   int n_errors = 0;

   regs_wb_arb #(.W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .alu_valid   (alu_valid),
      .alu_ready   (alu_ready),
      .alu_rd      (alu_rd),
      .alu_val     (alu_val),
      .lsu_valid   (lsu_valid),
      .lsu_ready   (lsu_ready),
      .lsu_rd      (lsu_rd),
      .lsu_val     (lsu_val),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .ren         (ren),
      .rs1         (rs1),
      .rs2         (rs2),
      .stall       (stall),
      .wen         (wen),
      .rd          (rd),
      .rd_val      (rd_val),
      .fwd1_hit    (fwd1_hit),
      .fwd1_val    (fwd1_val),
      .fwd2_hit    (fwd2_hit),
      .fwd2_val    (fwd2_val)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 0; alu_rd = 0; alu_val = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_val = 0;
      issue_valid = 0; issue_rd = 0;
      ren = 0; rs1 = 0; rs2 = 0;
   endtask

   initial begin
      idle_inputs();
      rst_n = 0;

      // ---------------- reset with random inputs ----------------
      for (int i = 0; i < 4; i++) begin
         alu_valid   = 1'($urandom); alu_rd = 5'($urandom); alu_val = $urandom;
         lsu_valid   = 1'($urandom); lsu_rd = 5'($urandom); lsu_val = $urandom;
         issue_valid = 1'($urandom); issue_rd = 5'($urandom);
         ren = 1'b1; rs1 = 5'($urandom); rs2 = 5'($urandom);
         step();
         check("rst_wen",   W'(wen), 0);
         check("rst_fwd1",  W'(fwd1_hit), 0);
         check("rst_fwd2",  W'(fwd2_hit), 0);
         check("rst_stall", W'(stall), 0);
      end
      check("rst_rd",     W'(rd), 0);
      check("rst_rd_val", rd_val, 0);

      // ---------------- first write after release ----------------
      idle_inputs();
      rst_n = 1;
      alu_valid = 1; alu_rd = 5; alu_val = 32'h11;
      #1;
      check("rel_alu_ready", W'(alu_ready), 1);
      step();
      alu_valid = 0;
      check("rel_wen",    W'(wen), 1);
      check("rel_rd",     W'(rd), 5);
      check("rel_rd_val", rd_val, 32'h11);

      // ---------------- contention from fresh reset ----------------
      rst_n = 0; #1; rst_n = 1;
      alu_valid = 1; alu_rd = 3; alu_val = 32'hA;
      lsu_valid = 1; lsu_rd = 4; lsu_val = 32'hB;
      #1;
      check("c0_alu_ready", W'(alu_ready), 1);
      check("c0_lsu_ready", W'(lsu_ready), 0);
      step();
      check("c0_wen",    W'(wen), 1);
      check("c0_rd",     W'(rd), 3);
      check("c0_rd_val", rd_val, 32'hA);
      check("c1_alu_ready", W'(alu_ready), 0);
      check("c1_lsu_ready", W'(lsu_ready), 1);
      step();
      check("c1_rd",     W'(rd), 4);
      check("c1_rd_val", rd_val, 32'hB);
      // Four more contended cycles: ALU, LSU, ALU, LSU
      for (int i = 0; i < 4; i++) begin
         check("alt_alu_ready", W'(alu_ready), (i % 2 == 0) ? 1 : 0);
         check("alt_lsu_ready", W'(lsu_ready), (i % 2 == 0) ? 0 : 1);
         step();
         check("alt_wen",    W'(wen), 1);
         check("alt_rd",     W'(rd), (i % 2 == 0) ? 3 : 4);
         check("alt_rd_val", rd_val, (i % 2 == 0) ? 32'hA : 32'hB);
      end
      idle_inputs();
      step();
      check("idle_wen",    W'(wen), 0);
      check("idle_rd",     W'(rd), 4);
      check("idle_rd_val", rd_val, 32'hB);

      // ---------------- x0 write is accepted but dropped ----------------
      lsu_valid = 1; lsu_rd = 0; lsu_val = 32'hFFFF_FFFF;
      #1;
      check("x0_lsu_ready", W'(lsu_ready), 1);
      step();
      lsu_valid = 0;
      check("x0_wen",    W'(wen), 0);
      check("x0_rd_val", rd_val, 32'hFFFF_FFFF);

      // ---------------- scoreboard ----------------
      issue_valid = 1; issue_rd = 7;
      ren = 1; rs1 = 7; rs2 = 0;
      #1;
      check("sb_stall_pre", W'(stall), 0);
      step();
      issue_valid = 0;
      check("sb_stall_set", W'(stall), 1);
      alu_valid = 1; alu_rd = 7; alu_val = 32'h77;
      step();
      alu_valid = 0;
      check("sb_wen7", W'(wen), 1);
      check("sb_stall_during_wen", W'(stall), 1);
      step();
      check("sb_stall_cleared", W'(stall), 0);
      check("sb_fwd1_hit", W'(fwd1_hit), 1);
      check("sb_fwd1_val", fwd1_val, 32'h77);
      check("sb_fwd2_hit", W'(fwd2_hit), 0);
      // Set and clear on the same edge: set wins
      issue_valid = 1; issue_rd = 7;
      step();
      issue_valid = 0;
      check("sb2_stall_set", W'(stall), 1);
      alu_valid = 1; alu_rd = 7; alu_val = 32'h78;
      step();
      alu_valid = 0;
      check("sb2_wen7", W'(wen), 1);
      issue_valid = 1; issue_rd = 7;
      step();
      issue_valid = 0;
      check("sb2_same_edge_stall", W'(stall), 1);
      step();
      check("sb2_stall_holds", W'(stall), 1);

      // ---------------- forwarding ----------------
      ren = 0; rs1 = 0;
      alu_valid = 1; alu_rd = 9; alu_val = 32'h1234;
      step();
      alu_valid = 0;
      check("fw_wen9", W'(wen), 1);
      ren = 1; rs1 = 9; rs2 = 2;
      #1;
      check("fw_stall", W'(stall), 0);
      step();
      check("fw_fwd1_hit", W'(fwd1_hit), 1);
      check("fw_fwd1_val", fwd1_val, 32'h1234);
      check("fw_fwd2_hit", W'(fwd2_hit), 0);
      ren = 0;
      step();
      check("fw_ren0_hit",  W'(fwd1_hit), 0);
      check("fw_ren0_hold", fwd1_val, 32'h1234);

      // ---------------- async reset mid-flight ----------------
      alu_valid = 1; alu_rd = 10; alu_val = 32'h5;
      step();
      alu_valid = 0;
      ren = 1; rs1 = 7; rs2 = 0;
      #1;
      check("ar_wen_before",   W'(wen), 1);
      check("ar_stall_before", W'(stall), 1);
      #1;
      rst_n = 0;
      #1;
      check("ar_wen",      W'(wen), 0);
      check("ar_rd",       W'(rd), 0);
      check("ar_rd_val",   rd_val, 0);
      check("ar_stall",    W'(stall), 0);
      check("ar_fwd1_val", fwd1_val, 0);
      #1;
      rst_n = 1;
      ren = 0;
      step();
      check("ar_no_replay", W'(wen), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog so the bench always terminates
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule : tb_regs_wb_arb
`default_nettype wire
